// File: rtl/bram_ctrl.sv
`timescale 1ns/1ps
// Parametrised word memory for the soft-core bus: byte-masked writes, read-first
// reads with 1- or 2-cycle latency, and a post-reset sequencer that zeroes every word.
module bram_ctrl #(
    parameter int ADDR_BITS      = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_BITS+1:2]    mem_addr,
    input  logic                    cs,
    input  logic                    rd,
    input  logic                    wr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_wmask,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    rdata_valid,
    output logic                    busy
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int BYTES = DATA_WIDTH / 8;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("bram_ctrl: READ_LATENCY must be 1 or 2");
    end

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   clr_cnt;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic                   rd_acc, wr_acc;
    logic                   vld_p0;
    logic [DATA_WIDTH-1:0]  rdata_p0;

    assign busy   = (state_q == CLEAR);
    assign rd_acc = cs & rd & ~busy;
    assign wr_acc = cs & wr & ~busy;

    always_comb begin
        state_d = state_q;
        if (state_q == CLEAR && (&clr_cnt))
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (busy)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // The clear sweep owns the array while busy; bus writes are locked out then.
    always_ff @(posedge clk) begin
        if (busy) begin
            if (!reset)
                mem[clr_cnt] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < BYTES; i++)
                if (mem_wmask[i])
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    // Stage p0: array read; sampling before the same-edge write gives read-first.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0   <= 1'b0;
            rdata_p0 <= '0;
        end else begin
            vld_p0 <= rd_acc;
            if (rd_acc)
                rdata_p0 <= mem[mem_addr];
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  vld_p1;
        logic [DATA_WIDTH-1:0] rdata_p1;

        // Stage p1: extra output register; reset discards any read in flight.
        always_ff @(posedge clk) begin
            if (reset) begin
                vld_p1   <= 1'b0;
                rdata_p1 <= '0;
            end else begin
                vld_p1 <= vld_p0;
                if (vld_p0)
                    rdata_p1 <= rdata_p0;
            end
        end

        assign mem_rdata   = rdata_p1;
        assign rdata_valid = vld_p1;
    end else begin : g_lat1
        assign mem_rdata   = rdata_p0;
        assign rdata_valid = vld_p0;
    end

endmodule

// File: tb/tb_bram_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for bram_ctrl: latency-1 and latency-2 instances share one stimulus
// stream; a bench-side memory/clear model predicts every read and the busy flag.
module tb_bram_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:2]  mem_addr = '0;
    logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wmask = '0;

    logic [31:0] rdata1, rdata2;
    logic        vld1, vld2, busy1, busy2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bram_ctrl #(.ADDR_BITS(5), .DATA_WIDTH(32), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .cs(cs), .rd(rd), .wr(wr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rdata(rdata1), .rdata_valid(vld1), .busy(busy1));

    bram_ctrl #(.ADDR_BITS(5), .DATA_WIDTH(32), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_dut2 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .cs(cs), .rd(rd), .wr(wr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rdata(rdata2), .rdata_valid(vld2), .busy(busy2));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model, advanced on every rising edge.
    logic [31:0] m_mem [32];
    logic        m_busy = 1'b1;
    int          m_cnt = 0;
    int          cyc = 0;
    logic [31:0] q1d[$], q2d[$];
    int          q1c[$], q2c[$];

    initial for (int i = 0; i < 32; i++) m_mem[i] = '0;

    always @(posedge clk) begin
        logic acc_rd, acc_wr;
        cyc++;
        acc_rd = cs & rd & ~m_busy;
        acc_wr = cs & wr & ~m_busy;
        if (acc_rd) begin
            q1d.push_back(m_mem[mem_addr]); q1c.push_back(cyc);
            q2d.push_back(m_mem[mem_addr]); q2c.push_back(cyc);
        end
        if (acc_wr)
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) m_mem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
        if (reset) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            q1d.delete(); q1c.delete(); q2d.delete(); q2c.delete();
        end else if (m_busy) begin
            m_mem[m_cnt] = '0;
            if (m_cnt == 31) m_busy = 1'b0;
            m_cnt++;
        end
    end

    // Output monitor, sampled 1 ns after each rising edge.
    logic [31:0] exp_rd1 = '0, exp_rd2 = '0;
    logic [31:0] last_rd1 = '0, last_rd2 = '0;
    int          pulses2 = 0;

    always @(posedge clk) begin
        #1;
        check_eq("busy1", {31'b0, busy1}, {31'b0, m_busy});
        check_eq("busy2", {31'b0, busy2}, {31'b0, m_busy});
        if (reset) begin
            exp_rd1 = '0;
            exp_rd2 = '0;
        end
        if (q1c.size() > 0 && q1c[0] == cyc) begin
            check_eq("vld1", {31'b0, vld1}, 32'd1);
            exp_rd1 = q1d.pop_front();
            void'(q1c.pop_front());
        end else begin
            check_eq("vld1_idle", {31'b0, vld1}, 32'd0);
        end
        check_eq("rdata1", rdata1, exp_rd1);
        if (q2c.size() > 0 && q2c[0] + 1 == cyc) begin
            check_eq("vld2", {31'b0, vld2}, 32'd1);
            exp_rd2 = q2d.pop_front();
            void'(q2c.pop_front());
        end else begin
            check_eq("vld2_idle", {31'b0, vld2}, 32'd0);
        end
        check_eq("rdata2", rdata2, exp_rd2);
        if (vld1) last_rd1 = rdata1;
        if (vld2) begin
            last_rd2 = rdata2;
            pulses2++;
        end
    end

    task automatic drive(input logic c, input logic r, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        cs = c; rd = r; wr = w; mem_addr = a; mem_wdata = d; mem_wmask = m;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 4'd0);
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic write_word(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
        drive(1'b1, 1'b0, 1'b1, a, d, m);
        idle(1);
    endtask

    task automatic read_word(input logic [4:0] a);
        drive(1'b1, 1'b1, 1'b0, a, 32'd0, 4'd0);
        idle(4);
    endtask

    // Releases reset at a falling edge and counts edges until busy drops.
    task automatic release_and_measure(input string tag, input int exp_len);
        int n;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (busy1 && n < 100);
        check_eq(tag, n, exp_len);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int p;
        repeat (3) @(negedge clk);
        release_and_measure("clr_len_init", 32);

        // Clear after reset wipes earlier contents.
        write_word(5'd3, 32'hDEADBEEF, 4'hF);
        read_word(5'd3);
        check_eq("pre_clear_w3", last_rd1, 32'hDEADBEEF);
        pulse_reset();
        release_and_measure("clr_len", 32);
        read_word(5'd3);
        check_eq("post_clear_w3", last_rd1, 32'h0);

        // Byte mask merge.
        write_word(5'd2, 32'h11223344, 4'hF);
        write_word(5'd2, 32'hAABBCCDD, 4'h5);
        write_word(5'd2, 32'hFFFFFFFF, 4'h0);
        read_word(5'd2);
        check_eq("bytemask", last_rd1, 32'h11BB33DD);

        // Read-first on simultaneous access.
        write_word(5'd5, 32'h1, 4'hF);
        drive(1'b1, 1'b1, 1'b1, 5'd5, 32'h2, 4'hF);
        idle(4);
        check_eq("rdfirst_old", last_rd1, 32'h1);
        check_eq("rdfirst_old2", last_rd2, 32'h1);
        read_word(5'd5);
        check_eq("rdfirst_new", last_rd1, 32'h2);

        // Back-to-back reads through both latencies.
        write_word(5'd0, 32'hA0, 4'hF);
        write_word(5'd1, 32'hA1, 4'hF);
        write_word(5'd2, 32'hA2, 4'hF);
        p = pulses2;
        drive(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b1, 1'b0, 5'd1, 32'd0, 4'd0);
        drive(1'b1, 1'b1, 1'b0, 5'd2, 32'd0, 4'd0);
        idle(5);
        check_eq("lat2_pulses", pulses2 - p, 3);
        check_eq("lat2_last", last_rd2, 32'hA2);
        check_eq("lat1_last", last_rd1, 32'hA2);

        // Requests while busy are dropped.
        write_word(5'd7, 32'h12345678, 4'hF);
        pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        p = pulses2;
        drive(1'b1, 1'b0, 1'b1, 5'd7, 32'hFF, 4'hF);
        drive(1'b1, 1'b1, 1'b0, 5'd7, 32'd0, 4'd0);
        idle(40);
        check_eq("busy_drop_pulses", pulses2 - p, 0);
        check_eq("busy_done", {31'b0, busy1}, 32'd0);
        read_word(5'd7);
        check_eq("busy_drop_w7", last_rd1, 32'h0);

        // Reset mid-clear restarts the full sweep.
        pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        release_and_measure("clr_len_restart", 32);

        // Reset with a latency-2 read still in flight.
        write_word(5'd4, 32'h55, 4'hF);
        read_word(5'd4);
        check_eq("pre_abort_rd", last_rd2, 32'h55);
        p = pulses2;
        drive(1'b1, 1'b1, 1'b0, 5'd4, 32'd0, 4'd0);
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #2;
        check_eq("abort_no_pulse", pulses2 - p, 0);
        check_eq("abort_rdata2", rdata2, 32'h0);
        check_eq("abort_rdata1", rdata1, 32'h0);
        release_and_measure("clr_len_after_abort", 32);

        idle(3);
        check_eq("q1_empty", q1d.size(), 0);
        check_eq("q2_empty", q2d.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_ctrl.md
# bram_ctrl

Parametrised on-chip word memory for the soft-core's peripheral/RAM bus, successor to the fixed 32×32 block RAM. Adds configurable depth and width, a byte write mask, a read-data valid strobe with selectable read latency (1 or 2 cycles), and a post-reset clear sequencer that zeroes the whole array before accepting bus traffic. It sits behind the address decoder and is selected by `cs`.

## Interface
Parameters:
- `ADDR_BITS`, default 5: word-address width; depth = 2^ADDR_BITS words.
- `DATA_WIDTH`, default 32: word width; must be a multiple of 8.
- `READ_LATENCY`, default 1: 1 or 2 cycles from accepted read to `rdata_valid`; any other value is an elaboration error.
- `CLEAR_ON_RESET`, default 1: 1 = zero all words after reset; 0 = no clear, memory contents undefined after power-up.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_addr` in [ADDR_BITS+1:2]: byte address of the word; bits [1:0] are not present.
- `cs` in 1: block select.
- `rd` in 1: read request, qualified by `cs`.
- `wr` in 1: write request, qualified by `cs`.
- `mem_wdata` in DATA_WIDTH: write data.
- `mem_wmask` in DATA_WIDTH/8: byte enables; bit i writes bits [8i+7:8i].
- `mem_rdata` out DATA_WIDTH: read data.
- `rdata_valid` out 1: one-cycle pulse when `mem_rdata` carries newly read data.
- `busy` out 1: high while the clear sequence runs; accesses are ignored while high.

## Operation
- Accept condition: read accepted when `cs & rd & ~busy` at an edge; write accepted when `cs & wr & ~busy`.
- Write: for each i with `mem_wmask[i]`=1, byte i of word `mem_addr` takes byte i of `mem_wdata`; other bytes unchanged. Mask all-zero = no change.
- Read: word `mem_addr` returned on `mem_rdata`, `rdata_valid` pulses.
- Simultaneous read and write to the same address: read-first; returned data is the value before the write.
- `mem_rdata` holds its last value when no read completes; it is never cleared by a write or by the clear sequence.
- Clear sequencer states: IDLE, CLEAR.
  - `reset` high: state = CLEAR (if `CLEAR_ON_RESET`=1) else IDLE; clear counter = 0.
  - CLEAR, `reset` low: each edge writes word[counter] = 0, counter += 1; on the edge writing word 2^ADDR_BITS−1, state → IDLE.
  - IDLE: stays IDLE until `reset`.
- `busy` = (state == CLEAR).
- Reset mid-clear: counter restarts at 0; full clear repeats.
- Reset mid-read: any read in the latency pipeline is discarded; no `rdata_valid` pulse emerges.
- Requests during `busy` are dropped, not queued; the master must poll `busy` or wait.

## Timing
- Reset values: `mem_rdata` = 0, `rdata_valid` = 0, `busy` = 1 if `CLEAR_ON_RESET`=1 else 0.
- Clear duration: `busy` is high during reset and for exactly 2^ADDR_BITS edges after the first edge with `reset` low; the first access can be accepted at edge 2^ADDR_BITS+1.
- `READ_LATENCY`=1: read accepted at edge N; `mem_rdata` and `rdata_valid`=1 are valid after edge N, and `rdata_valid` returns to 0 after edge N+1 unless another read is accepted.
- `READ_LATENCY`=2: data is registered once more; `mem_rdata` and `rdata_valid` are updated after edge N+1. Back-to-back reads give one result per cycle.
- Write data is visible to a read accepted on the next edge.

## Test plan
- Clear: DEPTH=32, `CLEAR_ON_RESET`=1; write word 3 = 0xDEADBEEF, pulse reset, wait until `busy`=0 -> `busy` high for exactly 32 cycles after reset release, then read 3 -> 0x00000000.
- Byte mask: write 0x11223344 mask 0xF to addr 0x08, then 0xAABBCCDD mask 0x5 -> read 0x08 returns 0x11BB33DD.
- Read-first: word 5 = 0x1, one cycle with rd=wr=1 to word 5 writing 0x2 -> `mem_rdata`=0x1, next read returns 0x2.
- Latency: `READ_LATENCY`=2, reads to words 0,1,2 on consecutive edges -> `rdata_valid` high 3 consecutive cycles starting 2 edges after first accept, data in order.
- Busy drop: write 0xFF to word 7 while `busy`=1 -> no `rdata_valid` pulse, and after clear word 7 reads 0.
- Reset mid-clear and mid-read: assert reset at clear count 10 -> `busy` stays high 32 further cycles; reset during a pending latency-2 read -> no `rdata_valid` pulse, `mem_rdata`=0.
